// File: rtl/sb_3320_path_pkg.sv
// Shared path-planning types and constants: node ids, path geometry and the sequencer state set.
// The planner and map_direction use the same definitions.
package sb_3320_path_pkg;

    localparam int N_NODES   = 10;
    localparam int NODE_W    = 5;
    localparam int PAD_NODE  = 27;
    localparam int PREV_INIT = 30;
    localparam int NONE_NODE = 31;
    localparam int IDX_W     = $clog2(N_NODES);

    typedef logic [NODE_W-1:0] node_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic logic is_pad(input node_t n);
        return n == node_t'(PAD_NODE);
    endfunction

endpackage

// File: rtl/sb_3320_path_sequencer.sv
// Holds one planned path, skips its leading PAD slots and steps through it one node per advance,
// presenting the (prev, cur, next) triple for direction mapping.
module sb_3320_path_sequencer
    import sb_3320_path_pkg::*;
(
    input  logic                      clk_50,
    input  logic                      rst_n,
    input  logic                      path_valid,
    input  logic [N_NODES*NODE_W-1:0] path,
    input  logic                      advance,
    input  logic                      abort,
    output logic                      busy,
    output logic                      triple_valid,
    output logic [NODE_W-1:0]         prev_node,
    output logic [NODE_W-1:0]         cur_node,
    output logic [NODE_W-1:0]         next_node,
    output logic                      at_end,
    output logic                      done,
    output logic                      error,
    output state_t                    fsm_state
);

    // Handshake: path_valid, advance and abort are single-cycle strobes sampled on the rising
    // clock edge; there is no back-pressure, so a strobe that arrives in a state that cannot use
    // it is simply dropped. Outputs are registered and change the cycle after the strobe.

    state_t state_q, state_d;
    idx_t   idx_q, idx_d;
    node_t  slots [N_NODES];
    node_t  prev_q, prev_d, cur_q, cur_d, next_q, next_d;
    logic   tv_q, tv_d, at_end_q, at_end_d, done_q, done_d, error_q, error_d;
    logic   load;

    idx_t   idx_m1, idx_m2;
    node_t  cur_slot, below1, below2;

    // Clamped neighbour indices keep every array read in range even at slot 0.
    assign idx_m1   = (idx_q  != '0) ? idx_q  - idx_t'(1) : '0;
    assign idx_m2   = (idx_m1 != '0) ? idx_m1 - idx_t'(1) : '0;
    assign cur_slot = slots[idx_q];
    assign below1   = slots[idx_m1];
    assign below2   = slots[idx_m2];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        prev_d   = prev_q;
        cur_d    = cur_q;
        next_d   = next_q;
        tv_d     = tv_q;
        at_end_d = at_end_q;
        done_d   = 1'b0;
        error_d  = error_q;
        load     = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            tv_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (path_valid) begin
                        load    = 1'b1;
                        idx_d   = idx_t'(N_NODES - 1);
                        error_d = 1'b0;
                        state_d = ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (is_pad(cur_slot)) begin
                        if (idx_q != '0) begin
                            idx_d = idx_m1;
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        prev_d   = node_t'(PREV_INIT);
                        cur_d    = cur_slot;
                        next_d   = (idx_q != '0) ? below1 : node_t'(NONE_NODE);
                        at_end_d = (idx_q == '0);
                        tv_d     = 1'b1;
                        state_d  = ST_READY;
                    end
                end
                ST_READY: begin
                    if (advance) begin
                        if (idx_q == '0) begin
                            done_d  = 1'b1;
                            tv_d    = 1'b0;
                            state_d = ST_IDLE;
                        end else if (is_pad(below1)) begin
                            error_d = 1'b1;
                            tv_d    = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d    = idx_m1;
                            prev_d   = cur_q;
                            cur_d    = next_q;
                            next_d   = (idx_m1 != '0) ? below2 : node_t'(NONE_NODE);
                            at_end_d = (idx_m1 == '0);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tv_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= idx_t'(N_NODES - 1);
            prev_q   <= node_t'(PREV_INIT);
            cur_q    <= node_t'(PREV_INIT);
            next_q   <= node_t'(NONE_NODE);
            tv_q     <= 1'b0;
            at_end_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            prev_q   <= prev_d;
            cur_q    <= cur_d;
            next_q   <= next_d;
            tv_q     <= tv_d;
            at_end_q <= at_end_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Path storage only changes on an accepted path; reset refills it with PAD.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) slots[i] <= node_t'(PAD_NODE);
        end else if (load) begin
            for (int i = 0; i < N_NODES; i++) slots[i] <= path[i*NODE_W +: NODE_W];
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign triple_valid = tv_q;
    assign prev_node    = prev_q;
    assign cur_node     = cur_q;
    assign next_node    = next_q;
    assign at_end       = at_end_q;
    assign done         = done_q;
    assign error        = error_q;
    assign fsm_state    = state_q;

endmodule
